vga_timing_gen: RTL and testbench

Generates VGA raster timing: horizontal/vertical sync, the `active` (display-enable) qualifier, and current pixel coordinates. Drives the pixel-colour stage downstream, which gates RGB with `active`. Counters advance on a pixel-clock enable, so the block runs from the system clock with a divided-rate `pix_en` strobe. Defaults give 640x480 @ 60 Hz with a 25 MHz pixel rate.

---
 rtl/vga_timing_gen_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 23 ++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 tb/tb_vga_timing_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz, 25 MHz pixel rate) for the
// timing generator, the colour stage and the top level.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_CNT_W    = 10;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    localparam int VGA_H_TOTAL = axis_total(VGA_H_ACTIVE, VGA_H_FP, VGA_H_SYNC, VGA_H_BP);
    localparam int VGA_V_TOTAL = axis_total(VGA_V_ACTIVE, VGA_V_FP, VGA_V_SYNC, VGA_V_BP);

    // Raster region along one axis, in scan order.
    typedef enum logic [1:0] {
        REGION_ACTIVE = 2'd0,
        REGION_FP     = 2'd1,
        REGION_SYNC   = 2'd2,
        REGION_BP     = 2'd3
    } region_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: pixel strobe into the generator, sync/active/coords out.
interface vga_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             pix_en;
    logic             hsync;
    logic             vsync;
    logic             active;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             line_start;
    logic             frame_start;

    // master = timing generator, slave = pixel/colour stage (and strobe source)
    modport master (
        input  pix_en,
        output hsync, vsync, active, x, y, line_start, frame_start
    );
    modport slave (
        output pix_en,
        input  hsync, vsync, active, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters advanced by pix_en, with sync,
// active and coordinate outputs registered from the next-state counter values.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = VGA_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SYNC_BEG  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] hcnt_reg, hcnt_next;
    logic [CNT_W-1:0] vcnt_reg, vcnt_next;

    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             active_reg, active_next;
    logic [CNT_W-1:0] x_reg;
    logic [CNT_W-1:0] y_reg;
    logic             line_start_reg, line_start_next;
    logic             frame_start_reg, frame_start_next;

    logic             h_wrap;

    // Counter advance; vertical steps on the same strobe as the horizontal wrap.
    always_comb begin
        hcnt_next = hcnt_reg;
        vcnt_next = vcnt_reg;
        h_wrap    = (hcnt_reg == H_LAST);
        if (vga.pix_en) begin
            if (h_wrap) begin
                hcnt_next = '0;
                vcnt_next = (vcnt_reg == V_LAST) ? '0 : vcnt_reg + 1'b1;
            end else begin
                hcnt_next = hcnt_reg + 1'b1;
            end
        end
    end

    // Decodes look at the next counter values so the registered outputs line
    // up with x/y on the same edge, without a cycle of skew.
    always_comb begin
        active_next      = (hcnt_next < H_ACT_END) && (vcnt_next < V_ACT_END);
        hsync_next       = ((hcnt_next >= H_SYNC_BEG) && (hcnt_next < H_SYNC_END)) ? HS_POL : ~HS_POL;
        vsync_next       = ((vcnt_next >= V_SYNC_BEG) && (vcnt_next < V_SYNC_END)) ? VS_POL : ~VS_POL;
        line_start_next  = vga.pix_en && (hcnt_next == '0);
        frame_start_next = vga.pix_en && (hcnt_next == '0) && (vcnt_next == '0);
    end

    // Counters start at the last pixel so the first strobe lands on (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt_reg        <= H_LAST;
            vcnt_reg        <= V_LAST;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            active_reg      <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            hcnt_reg        <= hcnt_next;
            vcnt_reg        <= vcnt_next;
            line_start_reg  <= line_start_next;
            frame_start_reg <= frame_start_next;
            if (vga.pix_en) begin
                hsync_reg  <= hsync_next;
                vsync_reg  <= vsync_next;
                active_reg <= active_next;
                x_reg      <= hcnt_next;
                y_reg      <= vcnt_next;
            end
        end
    end

    assign vga.hsync       = hsync_reg;
    assign vga.vsync       = vsync_reg;
    assign vga.active      = active_reg;
    assign vga.x           = x_reg;
    assign vga.y           = y_reg;
    assign vga.line_start  = line_start_reg;
    assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small
// positive-polarity instance share the strobe and reset, checked every cycle.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.CNT_W(10)) ia ();
    vga_timing_gen_if #(.CNT_W(6))  ib ();

    assign ia.pix_en = pix_en;
    assign ib.pix_en = pix_en;

    vga_timing_gen dut_a (
        .clk (clk),
        .rst (rst),
        .vga (ia.master)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (4), .H_SYNC (6), .H_BP (4),
        .V_ACTIVE (10), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HS_POL   (1'b1), .VS_POL (1'b1), .CNT_W (6)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .vga (ib.master)
    );

    typedef struct {
        logic hs, vs, act, ls, fs;
        int   x, y;
    } exp_t;

    int     checks = 0;
    int     errors = 0;
    longint n      = 0;   // pix_en strobes accepted since reset release
    bit     strobe = 1'b0;
    int     cyc    = 0;

    // Raster position after n strobes, from plain arithmetic on the pixel index.
    function automatic exp_t model(input longint nn, input bit st,
                                   input int ha, input int hfp, input int hsw, input int hbp,
                                   input int va, input int vfp, input int vsw, input int vbp,
                                   input bit hpol, input bit vpol);
        exp_t   e;
        int     ht, vt;
        longint pos;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        if (nn == 0) begin
            e.x = 0; e.y = 0; e.act = 1'b0;
            e.hs = ~hpol; e.vs = ~vpol; e.ls = 1'b0; e.fs = 1'b0;
        end else begin
            pos   = (nn - 1) % longint'(ht * vt);
            e.x   = int'(pos % ht);
            e.y   = int'(pos / ht);
            e.act = (e.x < ha) && (e.y < va);
            e.hs  = (e.x >= ha + hfp && e.x < ha + hfp + hsw) ? hpol : ~hpol;
            e.vs  = (e.y >= va + vfp && e.y < va + vfp + vsw) ? vpol : ~vpol;
            e.ls  = st && (e.x == 0);
            e.fs  = st && (pos == 0);
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        e = model(n, strobe, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        chk("a_x",   32'(ia.x), e.x);
        chk("a_y",   32'(ia.y), e.y);
        chk("a_act", 32'(ia.active), 32'(e.act));
        chk("a_hs",  32'(ia.hsync), 32'(e.hs));
        chk("a_vs",  32'(ia.vsync), 32'(e.vs));
        chk("a_ls",  32'(ia.line_start), 32'(e.ls));
        chk("a_fs",  32'(ia.frame_start), 32'(e.fs));
        e = model(n, strobe, 16, 4, 6, 4, 10, 2, 2, 3, 1'b1, 1'b1);
        chk("b_x",   32'(ib.x), e.x);
        chk("b_y",   32'(ib.y), e.y);
        chk("b_act", 32'(ib.active), 32'(e.act));
        chk("b_hs",  32'(ib.hsync), 32'(e.hs));
        chk("b_vs",  32'(ib.vsync), 32'(e.vs));
        chk("b_ls",  32'(ib.line_start), 32'(e.ls));
        chk("b_fs",  32'(ib.frame_start), 32'(e.fs));
    endtask

    // Drive at the falling edge, let one rising edge act, check at the next falling edge.
    task automatic step(input bit en);
        pix_en = en;
        @(posedge clk);
        if (rst) begin
            if (en) n++;
            strobe = en;
        end else begin
            strobe = 1'b0;
        end
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    initial begin
        int last_fs_b, last_ls_a, hs_low_a, stop_at;
        rst    = 1'b0;
        pix_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all();                                    // reset state

        // Continuous strobe: >2 lines of 640x480, several small frames.
        rst       = 1'b1;
        last_fs_b = -1;
        last_ls_a = -1;
        hs_low_a  = 0;
        for (int i = 0; i < 1700; i++) begin
            step(1'b1);
            if (ib.frame_start === 1'b1) begin
                if (last_fs_b >= 0) chk("b_frame_period", cyc - last_fs_b, 510);
                last_fs_b = cyc;
            end
            if (ia.line_start === 1'b1) begin
                if (last_ls_a >= 0) begin
                    chk("a_line_period", cyc - last_ls_a, 800);
                    chk("a_hsync_width", hs_low_a, 96);
                end
                last_ls_a = cyc;
                hs_low_a  = 0;
            end
            if (ia.hsync === 1'b0) hs_low_a++;
        end
        $display("continuous strobe run done, cyc=%0d n=%0d", cyc, n);

        // Strobe every 4th clock: stretched waveform, pulses stay one clock.
        for (int i = 0; i < 2400; i++) step((i % 4) == 3);
        $display("1-in-4 strobe run done, cyc=%0d n=%0d", cyc, n);

        // Random strobe pattern.
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 2) == 0);
        $display("random strobe run done, cyc=%0d n=%0d", cyc, n);

        // Asynchronous reset mid-frame, visible before the next rising edge.
        stop_at = $urandom_range(50, 400);
        for (int i = 0; i < stop_at; i++) step(1'b1);
        #2;
        rst    = 1'b0;
        n      = 0;
        strobe = 1'b0;
        #1;
        check_all();
        @(negedge clk);
        for (int i = 0; i < 6; i++) step($urandom_range(0, 1) == 1);
        rst = 1'b1;
        step(1'b1);                                     // first strobe -> (0,0)
        chk("post_reset_fs", 32'(ia.frame_start), 32'd1);
        step(1'b0);
        chk("post_reset_fs_drop", 32'(ia.frame_start), 32'd0);
        $display("async reset at strobe %0d done, cyc=%0d", stop_at, cyc);

        // Long hold with no strobe, then more random traffic.
        for (int i = 0; i < 60; i++) step(1'b0);
        for (int i = 0; i < 3000; i++) step($urandom_range(0, 3) != 0);
        $display("hold and random run done, cyc=%0d n=%0d", cyc, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
